hazard_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage core.
- Decides, every cycle, the enable and flush of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Handles four events: instruction-memory wait, data-memory wait, load-use hazard, and control-flow flush. It also latches halt.
- Complements the EX-stage forwarding logic. It inserts only the one bubble forwarding cannot cover (load-use) and keeps stage register contents consistent while memory is busy.

---
 rtl/hazard_controller_if.sv | 45 ++++
 rtl/hazard_controller.sv | 120 ++++++++++++
 tb/tb_hazard_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Bundle of hazard-controller inputs (pipeline status) and outputs (latch control).
// The controller takes the slave side; the pipeline/bench takes the master side.
interface hazard_controller_if #(
   parameter int CNT_W = 16,
   parameter int REG_W = 5
);
   // pipeline status seen by the controller
   logic             ihit;
   logic             dhit;
   logic             dmemreq_o3;
   logic             memread_o2;
   logic [REG_W-1:0] wsel_o2;
   logic [REG_W-1:0] rsel1_o1;
   logic [REG_W-1:0] rsel2_o1;
   logic             usesrt_o1;
   logic             branch_taken_o2;
   logic             jump_o1;
   logic             halt_o4;
   // controls and debug driven by the controller
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             halt;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output ihit, dhit, dmemreq_o3, memread_o2, wsel_o2, rsel1_o1, rsel2_o1,
             usesrt_o1, branch_taken_o2, jump_o1, halt_o4,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
             halt, state, stall_cnt, flush_cnt
   );

   modport slave (
      input  ihit, dhit, dmemreq_o3, memread_o2, wsel_o2, rsel1_o1, rsel2_o1,
             usesrt_o1, branch_taken_o2, jump_o1, halt_o4,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
             halt, state, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage core: per-cycle PC/latch
// enables and bubble insertion for memory waits, load-use, branch and jump,
// plus a sticky halt and saturating stall/flush counters.
module hazard_controller #(
   parameter int CNT_W = 16,
   parameter int REG_W = 5
) (
   input  logic            CLK,
   input  logic            RST,
   hazard_controller_if.slave hc
);
   localparam logic [1:0] S_RUN     = 2'd0;
   localparam logic [1:0] S_LUSTALL = 2'd1;
   localparam logic [1:0] S_DWAIT   = 2'd2;
   localparam logic [1:0] S_HALT    = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [REG_W-1:0] wsel, rsel1, rsel2;
   logic             lu, dwait;
   logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic             ifid_flush, idex_flush;

   assign wsel  = hc.wsel_o2;
   assign rsel1 = hc.rsel1_o1;
   assign rsel2 = hc.rsel2_o1;

   // Hazard detection. In LUSTALL the ID/EX latch holds the bubble we just
   // inserted, so any load-use match there is stale and must not stall again.
   always_comb begin
      dwait = hc.dmemreq_o3 & ~hc.dhit;
      lu    = hc.memread_o2 & (wsel != '0)
              & ((wsel == rsel1) | (hc.usesrt_o1 & (wsel == rsel2)))
              & (state_q != S_LUSTALL);
   end

   // Prioritised enable/flush decode and next state. A halt arriving in
   // MEM/WB only redirects the next state; this cycle follows the other rules.
   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      state_d    = state_q;
      if (!RST && state_q != S_HALT) begin
         if (dwait) begin
            state_d = S_DWAIT;
         end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            state_d  = S_RUN;
            if (hc.branch_taken_o2) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (lu) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
               state_d    = S_LUSTALL;
            end else if (hc.jump_o1) begin
               ifid_flush = 1'b1;
               pc_en      = hc.ihit;
            end else if (!hc.ihit) begin
               pc_en      = 1'b0;
               ifid_flush = 1'b1;
            end
         end
         if (hc.halt_o4) begin
            state_d = S_HALT;
         end
      end
   end

   // Saturating performance counters; frozen once halted.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q != S_HALT) begin
         if (!pc_en && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if ((ifid_flush || idex_flush) && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end
   end

   // State and counter registers, cleared immediately by reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hc.pc_en      = pc_en;
   assign hc.ifid_en    = ifid_en;
   assign hc.idex_en    = idex_en;
   assign hc.exmem_en   = exmem_en;
   assign hc.memwb_en   = memwb_en;
   assign hc.ifid_flush = ifid_flush;
   assign hc.idex_flush = idex_flush;
   assign hc.halt       = (state_q == S_HALT);
   assign hc.state      = state_q;
   assign hc.stall_cnt  = stall_cnt_q;
   assign hc.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_hazard_controller;
   localparam int CW = 4;   // narrow counters so saturation is reached
   localparam int RW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   hazard_controller_if #(.CNT_W(CW), .REG_W(RW)) bus ();

   hazard_controller #(.CNT_W(CW), .REG_W(RW)) dut (
      .CLK (clk),
      .RST (rst),
      .hc  (bus)
   );

   always #5 clk = ~clk;

   // {pc,ifid,idex,exmem,memwb, ifid_flush,idex_flush, halt, state}
   function automatic logic [9:0] dut_vec();
      return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
              bus.ifid_flush, bus.idex_flush, bus.halt, bus.state};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      bus.ihit = 1'b1;            bus.dhit = 1'b1;
      bus.dmemreq_o3 = 1'b0;      bus.memread_o2 = 1'b0;
      bus.wsel_o2 = '0;           bus.rsel1_o1 = '0;
      bus.rsel2_o1 = '0;          bus.usesrt_o1 = 1'b0;
      bus.branch_taken_o2 = 1'b0; bus.jump_o1 = 1'b0;
      bus.halt_o4 = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   logic          m_halted = 1'b0, m_dwait = 1'b0, m_lustall = 1'b0;
   int            m_stall = 0, m_flush = 0;
   localparam int CMAX = (1 << CW) - 1;

   always @(negedge clk) begin
      logic pc, ie, de, xe, we, ifl, dfl, luh, dw;
      logic [1:0] es;
      if (rst) begin
         chk("model_ctl_rst", dut_vec(), 32'd0);
         chk("model_stall_rst", bus.stall_cnt, 32'd0);
         chk("model_flush_rst", bus.flush_cnt, 32'd0);
         m_halted = 1'b0; m_dwait = 1'b0; m_lustall = 1'b0;
         m_stall = 0; m_flush = 0;
      end else begin
         es = m_halted ? 2'd3 : m_dwait ? 2'd2 : m_lustall ? 2'd1 : 2'd0;
         {pc, ie, de, xe, we, ifl, dfl} = '0;
         dw  = bus.dmemreq_o3 && !bus.dhit;
         luh = bus.memread_o2 && bus.wsel_o2 != 0 && !m_lustall &&
               (bus.wsel_o2 == bus.rsel1_o1 ||
                (bus.usesrt_o1 && bus.wsel_o2 == bus.rsel2_o1));
         if (!m_halted && !dw) begin
            {pc, ie, de, xe, we} = 5'b11111;
            if (bus.branch_taken_o2)  {ifl, dfl} = 2'b11;
            else if (luh)             begin pc = 0; ie = 0; dfl = 1; end
            else if (bus.jump_o1)     begin ifl = 1; pc = bus.ihit; end
            else if (!bus.ihit)       begin ifl = 1; pc = 0; end
         end
         chk("model_ctl", dut_vec(), {22'd0, pc, ie, de, xe, we, ifl, dfl, m_halted, es});
         chk("model_stall", bus.stall_cnt, m_stall);
         chk("model_flush", bus.flush_cnt, m_flush);
         if (!m_halted) begin
            if (!pc && m_stall < CMAX)        m_stall++;
            if ((ifl || dfl) && m_flush < CMAX) m_flush++;
            m_lustall = !dw && !bus.branch_taken_o2 && luh;
            m_dwait   = dw;
            m_halted  = bus.halt_o4;
         end
      end
   end

   // ---------------- directed scenarios, then random traffic ----------------
   initial begin
      idle();
      tick(); look();
      chk("reset_ctl", dut_vec(), 10'b00000_00_0_00);
      chk("reset_stall", bus.stall_cnt, 0);
      tick(); rst = 1'b0;
      look(); chk("run_normal", dut_vec(), 10'b11111_00_0_00);

      // load-use: exactly one bubble
      tick(); bus.memread_o2 = 1; bus.wsel_o2 = 8; bus.rsel1_o1 = 8;
      look(); chk("lu_stall", dut_vec(), 10'b00111_01_0_00);
      tick(); bus.memread_o2 = 0;
      look(); chk("lu_after", dut_vec(), 10'b11111_00_0_01);
      chk("lu_stall_cnt", bus.stall_cnt, 1);
      tick(); look(); chk("lu_back_run", dut_vec(), 10'b11111_00_0_00);

      // store that does not read rt, and r0 destination: no stall
      tick(); bus.memread_o2 = 1; bus.wsel_o2 = 8; bus.rsel2_o1 = 8;
      bus.usesrt_o1 = 0; bus.rsel1_o1 = 3;
      look(); chk("no_rt_nostall", dut_vec(), 10'b11111_00_0_00);
      tick(); bus.wsel_o2 = 0; bus.rsel1_o1 = 0;
      look(); chk("r0_nostall", dut_vec(), 10'b11111_00_0_00);

      // taken branch overrides load-use
      tick(); bus.wsel_o2 = 8; bus.rsel1_o1 = 8; bus.branch_taken_o2 = 1;
      look(); chk("br_over_lu", dut_vec(), 10'b11111_11_0_00);
      tick(); idle();
      look(); chk("br_flush_cnt", bus.flush_cnt, 2);
      chk("br_stall_cnt", bus.stall_cnt, 1);

      // data wait for three cycles from a fresh reset
      tick(); rst = 1;
      look(); chk("rst2_ctl", dut_vec(), 0);
      tick(); rst = 0; bus.dmemreq_o3 = 1; bus.dhit = 0;
      look(); chk("dw_1", dut_vec(), 10'b00000_00_0_00);
      tick(); look(); chk("dw_2", dut_vec(), 10'b00000_00_0_10);
      tick(); look(); chk("dw_3", dut_vec(), 10'b00000_00_0_10);
      tick(); bus.dhit = 1;
      look(); chk("dw_done", dut_vec(), 10'b11111_00_0_10);
      tick(); idle();
      look(); chk("dw_stall_cnt", bus.stall_cnt, 3);
      chk("dw_run", dut_vec(), 10'b11111_00_0_00);

      // reset in the middle of a data wait
      tick(); bus.dmemreq_o3 = 1; bus.dhit = 0;
      look(); tick(); look(); chk("mid_dw_state", bus.state, 2);
      tick(); rst = 1;
      look(); chk("mid_rst_ctl", dut_vec(), 0);
      chk("mid_rst_stall", bus.stall_cnt, 0);
      chk("mid_rst_flush", bus.flush_cnt, 0);
      tick(); rst = 0; idle();
      look(); chk("post_rst_run", dut_vec(), 10'b11111_00_0_00);

      // halt: sticky until reset, counters frozen
      tick(); bus.halt_o4 = 1;
      look(); chk("halt_arrive", dut_vec(), 10'b11111_00_0_00);
      tick(); bus.halt_o4 = 0;
      for (int i = 0; i < 4; i++) begin
         look(); chk("halted", dut_vec(), 10'b00000_00_1_11);
         chk("halt_stall_frozen", bus.stall_cnt, 0);
         tick(); bus.ihit = i[0]; bus.dhit = ~i[0]; bus.dmemreq_o3 = i[1];
      end
      rst = 1; idle();
      tick(); rst = 0;

      // randomized traffic; the compare process checks every cycle
      for (int c = 0; c < 4000; c++) begin
         rst                 = ($urandom % 100) == 0;
         bus.ihit            = ($urandom % 10) < 8;
         bus.dhit            = ($urandom % 10) < 6;
         bus.dmemreq_o3      = ($urandom % 10) < 3;
         bus.memread_o2      = ($urandom % 10) < 4;
         bus.wsel_o2         = RW'($urandom_range(0, 3));
         bus.rsel1_o1        = RW'($urandom_range(0, 3));
         bus.rsel2_o1        = RW'($urandom_range(0, 3));
         bus.usesrt_o1       = $urandom % 2;
         bus.branch_taken_o2 = ($urandom % 10) == 0;
         bus.jump_o1         = ($urandom % 10) == 0;
         bus.halt_o4         = ($urandom % 150) == 0;
         tick();
      end
      look();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
